// File: rtl/ps2_steering_pkg.sv
// Shared scan-code constants and FSM encodings for the PS/2 steering block.
package ps2_steering_pkg;

   localparam logic [7:0] SCAN_EXT   = 8'hE0;
   localparam logic [7:0] SCAN_BRK   = 8'hF0;
   localparam logic [7:0] SCAN_LEFT  = 8'h6B;
   localparam logic [7:0] SCAN_RIGHT = 8'h74;

   localparam int unsigned FRAME_LAST_BIT = 10;

   typedef enum logic {
      IDLE,
      RECV
   } rx_state_t;

   typedef enum logic [1:0] {
      D_IDLE,
      D_EXT,
      D_BRK,
      D_EXT_BRK
   } dec_state_t;

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronizes and filters the keyboard clock, shifts in
// 11-bit frames and reports good bytes or framing/timeout errors.
module ps2_rx
   import ps2_steering_pkg::*;
#(
   parameter int unsigned FILTER_LEN     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       frame_err
);

   localparam int unsigned FW = $clog2(FILTER_LEN + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [1:0]    clk_sync;
   logic [1:0]    data_sync;
   logic          clk_filt;
   logic          clk_filt_q;
   logic [FW-1:0] filt_cnt;
   logic          fall;

   rx_state_t     state, state_n;
   logic [3:0]    bit_cnt, bit_cnt_n;
   logic [8:0]    shift, shift_n;
   logic [TW-1:0] timer, timer_n;
   logic [7:0]    rx_byte_n;
   logic          rx_valid_n;
   logic          frame_err_n;

   // Two-flop synchronizers, idle-high after reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
      end else begin
         clk_sync  <= {clk_sync[0], ps2_clk};
         data_sync <= {data_sync[0], ps2_data};
      end
   end

   // Filtered clock follows only after FILTER_LEN consecutive differing samples
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_filt   <= 1'b1;
         clk_filt_q <= 1'b1;
         filt_cnt   <= '0;
      end else begin
         clk_filt_q <= clk_filt;
         if (clk_sync[1] == clk_filt) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
            clk_filt <= clk_sync[1];
            filt_cnt <= '0;
         end else begin
            filt_cnt <= filt_cnt + FW'(1);
         end
      end
   end

   assign fall = clk_filt_q & ~clk_filt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shift     <= '0;
         timer     <= '0;
         rx_byte   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_n;
         bit_cnt   <= bit_cnt_n;
         shift     <= shift_n;
         timer     <= timer_n;
         rx_byte   <= rx_byte_n;
         rx_valid  <= rx_valid_n;
         frame_err <= frame_err_n;
      end
   end

   // Frame sequencing; shift[7:0] holds data and shift[8] parity once bit 9 is in
   always_comb begin
      state_n     = state;
      bit_cnt_n   = bit_cnt;
      shift_n     = shift;
      timer_n     = timer;
      rx_byte_n   = rx_byte;
      rx_valid_n  = 1'b0;
      frame_err_n = 1'b0;
      case (state)
         IDLE: begin
            timer_n = '0;
            if (fall && !data_sync[1]) begin
               state_n   = RECV;
               bit_cnt_n = 4'd1;
            end
         end
         RECV: begin
            if (fall) begin
               timer_n = '0;
               if (bit_cnt == 4'(FRAME_LAST_BIT)) begin
                  if (data_sync[1] && (^shift)) begin
                     rx_byte_n  = shift[7:0];
                     rx_valid_n = 1'b1;
                  end else begin
                     frame_err_n = 1'b1;
                  end
                  state_n   = IDLE;
                  bit_cnt_n = '0;
               end else begin
                  shift_n   = {data_sync[1], shift[8:1]};
                  bit_cnt_n = bit_cnt + 4'd1;
               end
            end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
               frame_err_n = 1'b1;
               state_n     = IDLE;
               bit_cnt_n   = '0;
               timer_n     = '0;
            end else begin
               timer_n = timer + TW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: rtl/ps2_steering.sv
// PS/2 keyboard steering: decodes extended left/right arrow make/break codes
// into held-key levels for the player controller.
module ps2_steering
   import ps2_steering_pkg::*;
#(
   parameter int unsigned FILTER_LEN     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       left,
   output logic       right,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       frame_err
);

   dec_state_t dec, dec_n;
   logic       left_n;
   logic       right_n;

   ps2_rx #(
      .FILTER_LEN     (FILTER_LEN),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_rx (
      .clk       (clk),
      .reset     (reset),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .rx_byte   (rx_byte),
      .rx_valid  (rx_valid),
      .frame_err (frame_err)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dec   <= D_IDLE;
         left  <= 1'b0;
         right <= 1'b0;
      end else begin
         dec   <= dec_n;
         left  <= left_n;
         right <= right_n;
      end
   end

   // Prefix tracking; only E0-prefixed arrow codes touch the steering levels
   always_comb begin
      dec_n   = dec;
      left_n  = left;
      right_n = right;
      if (frame_err) begin
         dec_n = D_IDLE;
      end else if (rx_valid) begin
         case (dec)
            D_IDLE: begin
               if (rx_byte == SCAN_EXT)      dec_n = D_EXT;
               else if (rx_byte == SCAN_BRK) dec_n = D_BRK;
            end
            D_EXT: begin
               dec_n = D_IDLE;
               if (rx_byte == SCAN_BRK)        dec_n   = D_EXT_BRK;
               else if (rx_byte == SCAN_EXT)   dec_n   = D_EXT;
               else if (rx_byte == SCAN_LEFT)  left_n  = 1'b1;
               else if (rx_byte == SCAN_RIGHT) right_n = 1'b1;
            end
            D_EXT_BRK: begin
               dec_n = D_IDLE;
               if (rx_byte == SCAN_LEFT)       left_n  = 1'b0;
               else if (rx_byte == SCAN_RIGHT) right_n = 1'b0;
            end
            D_BRK:   dec_n = D_IDLE;
            default: dec_n = D_IDLE;
         endcase
      end
   end

endmodule
